spi_master: RTL and testbench
=============================

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter: CLK_DIV, default 2, sck half-period = 2**CLK_DIV clk cycles; legal range 0..8.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request transfer of data_in; sampled only when busy=0.
REQ-005 data_in  input  8  byte to shift out, MSB first, captured on accepted start.
REQ-006 miso  input  1  serial data from slave.
REQ-007 mosi  output  1  serial data to slave.
REQ-008 sck  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-009 ss_n  output  1  slave select, active-low.
REQ-010 busy  output  1  high while a transfer is in progress.
REQ-011 data_out  output  8  last received byte; held until next completion.
REQ-012 new_data  output  1  one-cycle pulse: data_out just updated.

Function
REQ-013 States: IDLE, TRANSFER; all outputs registered.
REQ-014 IDLE: sck=0, ss_n=1, busy=0, mosi=0.
REQ-015 IDLE with start=1 -> next cycle: TRANSFER, busy=1, ss_n=0, sck=0, mosi=data_in[7], tx shift reg=data_in, divider=0, bit count=0.
REQ-016 start while busy=1 is ignored; data_in changes during TRANSFER have no effect.
REQ-017 Divider increments every TRANSFER cycle, wraps at 2**CLK_DIV-1; on wrap sck toggles.
REQ-018 Rising sck toggle: shift miso into rx shift reg LSB (MSB received first).
REQ-019 Falling sck toggle, bits 1..7: mosi = next lower tx bit; bit count +1.
REQ-020 Falling sck toggle after 8th rising edge: next cycle state=IDLE, busy=0, ss_n=1, mosi=0, data_out=rx byte, new_data=1 for exactly one cycle.
REQ-021 Transfer length from start-accepted cycle to new_data cycle: 16*2**CLK_DIV clk cycles (CLK_DIV=2 -> 64).
REQ-022 Exactly 8 sck rising edges per transfer; sck never glitches; sck low whenever ss_n=1.
REQ-023 start asserted in the new_data cycle is accepted (back-to-back); ss_n returns high for at least that one cycle.
REQ-024 data_out unchanged except at REQ-020 completion.

Reset
REQ-025 rst_n=0 at a clk edge -> next cycle: IDLE, sck=0, ss_n=1, mosi=0, busy=0, new_data=0, data_out=8'h00, divider and bit count=0.
REQ-026 Reset mid-transfer aborts: no new_data pulse, data_out keeps reset value 8'h00.
REQ-027 start during rst_n=0 is ignored.

Verification
REQ-028 CLK_DIV=2, miso tied to mosi, start with data_in=8'hA5 -> new_data exactly 64 cycles later, data_out=8'hA5, 8 sck rising edges, ss_n low throughout.
REQ-029 miso=1 constant, data_in=8'h00 -> data_out=8'hFF, mosi=0 at every rising sck edge.
REQ-030 start pulsed again at cycles 5 and 30 of a transfer with data_in=8'h3C -> ignored; result matches original byte, single new_data.
REQ-031 Back-to-back: start held high, data_in=8'h81 then 8'h7E, loopback -> two new_data pulses 65 cycles apart, data_out 8'h81 then 8'h7E, ss_n high one cycle between.
REQ-032 rst_n=0 for one cycle at cycle 20 of a transfer -> next cycle sck=0, ss_n=1, busy=0; no new_data; data_out=8'h00.
REQ-033 CLK_DIV=0, loopback 8'h5A -> new_data 16 cycles after start, data_out=8'h5A, sck toggles every cycle.

Source files
------------

// File: rtl/spi_if.sv
// Bus bundle between the SPI master and whatever drives and observes it.
interface spi_if;
  logic       start;
  logic [7:0] data_in;
  logic       miso;
  logic       mosi;
  logic       sck;
  logic       ss_n;
  logic       busy;
  logic [7:0] data_out;
  logic       new_data;

  modport master (
    input  start, data_in, miso,
    output mosi, sck, ss_n, busy, data_out, new_data
  );

  modport slave (
    output start, data_in, miso,
    input  mosi, sck, ss_n, busy, data_out, new_data
  );
endinterface

// File: rtl/spi_master.sv
// Byte-wide SPI mode-0 master; sck half-period is 2**CLK_DIV clk cycles, all outputs registered.
// state    | meaning
// IDLE     | ss_n high, sck low, waiting for start
// TRANSFER | ss_n low, shifting 8 bits MSB first
module spi_master #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  spi_if.master bus
);

  localparam int unsigned DIV_W = (CLK_DIV == 0) ? 1 : CLK_DIV;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'((1 << CLK_DIV) - 1);

  typedef enum logic {IDLE, TRANSFER} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;
  logic [7:0]       dout_q, dout_d;
  logic             sck_q, sck_d;
  logic             mosi_q, mosi_d;
  logic             ss_n_q, ss_n_d;
  logic             busy_q, busy_d;
  logic             nd_q, nd_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      ss_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      nd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      ss_n_q  <= ss_n_d;
      busy_q  <= busy_d;
      nd_q    <= nd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    ss_n_d  = ss_n_q;
    busy_d  = busy_q;
    nd_d    = 1'b0;

    case (state_q)
      IDLE: begin
        sck_d  = 1'b0;
        ss_n_d = 1'b1;
        busy_d = 1'b0;
        mosi_d = 1'b0;
        if (bus.start) begin
          state_d = TRANSFER;
          busy_d  = 1'b1;
          ss_n_d  = 1'b0;
          mosi_d  = bus.data_in[7];
          tx_d    = bus.data_in;
          div_d   = '0;
          bit_d   = '0;
        end
      end
      TRANSFER: begin
        if (div_q == DIV_MAX) begin
          div_d = '0;
          sck_d = ~sck_q;
          if (!sck_q) begin
            rx_d = {rx_q[6:0], bus.miso};
          end else if (bit_q == 3'd7) begin
            // last falling edge closes the frame
            state_d = IDLE;
            busy_d  = 1'b0;
            ss_n_d  = 1'b1;
            mosi_d  = 1'b0;
            dout_d  = rx_q;
            nd_d    = 1'b1;
            bit_d   = '0;
          end else begin
            bit_d  = bit_q + 3'd1;
            tx_d   = tx_q << 1;
            mosi_d = tx_q[6];
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.sck      = sck_q;
  assign bus.mosi     = mosi_q;
  assign bus.ss_n     = ss_n_q;
  assign bus.busy     = busy_q;
  assign bus.data_out = dout_q;
  assign bus.new_data = nd_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: CLK_DIV=2 and CLK_DIV=0 instances checked every cycle against a frame-level model.
module tb_spi_master;

  logic clk;
  logic rst_n2, rst_n0;
  logic loop2, loop0, mc2, mc0;
  int   cyc;
  int   n_checks, n_fail;

  spi_if if2 ();
  spi_if if0 ();

  assign if2.miso = loop2 ? if2.mosi : mc2;
  assign if0.miso = loop0 ? if0.mosi : mc0;

  spi_master #(.CLK_DIV(2)) dut2 (.clk(clk), .rst_n(rst_n2), .bus(if2.master));
  spi_master #(.CLK_DIV(0)) dut0 (.clk(clk), .rst_n(rst_n0), .bus(if0.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Frame-level model: position k within the frame decides every output.
  typedef struct {
    bit         valid;
    bit         active;
    int         k;
    logic [7:0] tx;
    logic [7:0] rx;
    logic [7:0] dout;
    bit         nd;
  } model_t;

  model_t m2, m0;

  function automatic model_t step(input model_t m, input logic rst, input logic st,
                                  input logic [7:0] din, input logic lp, input logic mc, input int n);
    model_t r = m;
    if (!rst) begin
      r.valid = 1; r.active = 0; r.k = 0; r.dout = 8'h00; r.nd = 0;
    end else if (r.active) begin
      r.k++;
      r.nd = 0;
      if (r.k == 16 * n) begin
        r.active = 0; r.nd = 1; r.dout = r.rx;
      end
    end else begin
      r.nd = 0;
      if (st) begin
        r.active = 1; r.k = 0; r.tx = din;
        r.rx = lp ? din : {8{mc}};
      end
    end
    return r;
  endfunction

  initial begin
    m2 = '{default: 0};
    m0 = '{default: 0};
  end

  always @(posedge clk) begin
    m2 = step(m2, rst_n2, if2.start, if2.data_in, loop2, mc2, 4);
    m0 = step(m0, rst_n0, if0.start, if0.data_in, loop0, mc0, 1);
  end

  task automatic cmp(input string tag, input model_t m, input int n, input logic sck,
                     input logic ss_n, input logic busy, input logic mosi, input logic nd,
                     input logic [7:0] dout);
    logic e_sck, e_ss, e_busy, e_mosi, e_nd;
    if (m.active) begin
      e_sck  = ((m.k / n) % 2) == 1;
      e_ss   = 1'b0;
      e_busy = 1'b1;
      e_mosi = m.tx[7 - m.k / (2 * n)];
      e_nd   = 1'b0;
    end else begin
      e_sck = 1'b0; e_ss = 1'b1; e_busy = 1'b0; e_mosi = 1'b0; e_nd = m.nd;
    end
    chk({tag, "_sck"},      32'(sck),  32'(e_sck));
    chk({tag, "_ss_n"},     32'(ss_n), 32'(e_ss));
    chk({tag, "_busy"},     32'(busy), 32'(e_busy));
    chk({tag, "_mosi"},     32'(mosi), 32'(e_mosi));
    chk({tag, "_new_data"}, 32'(nd),   32'(e_nd));
    chk({tag, "_data_out"}, 32'(dout), 32'(m.dout));
  endtask

  always @(negedge clk) begin
    if (m2.valid) cmp("d2", m2, 4, if2.sck, if2.ss_n, if2.busy, if2.mosi, if2.new_data, if2.data_out);
    if (m0.valid) cmp("d0", m0, 1, if0.sck, if0.ss_n, if0.busy, if0.mosi, if0.new_data, if0.data_out);
  end

  int   rise2, rise0, ones2, nd_tot2, nd_tot0;
  logic sck2_p, sck0_p;
  initial begin
    rise2 = 0; rise0 = 0; ones2 = 0; nd_tot2 = 0; nd_tot0 = 0; sck2_p = 0; sck0_p = 0;
  end
  always @(negedge clk) begin
    if (if2.sck === 1'b1 && sck2_p === 1'b0) begin
      rise2++;
      if (if2.mosi === 1'b1) ones2++;
    end
    if (if0.sck === 1'b1 && sck0_p === 1'b0) rise0++;
    if (if2.new_data === 1'b1) nd_tot2++;
    if (if0.new_data === 1'b1) nd_tot0++;
    sck2_p = if2.sck;
    sck0_p = if0.sck;
  end

  task automatic drv(input int sel, input logic s, input logic [7:0] d);
    if (sel == 2) begin if2.start = s; if2.data_in = d; end
    else begin if0.start = s; if0.data_in = d; end
  endtask

  function automatic logic nd_of(input int sel);
    return (sel == 2) ? if2.new_data : if0.new_data;
  endfunction

  function automatic logic [7:0] dout_of(input int sel);
    return (sel == 2) ? if2.data_out : if0.data_out;
  endfunction

  task automatic wait_nd(input int sel, input int budget, output int t);
    bit found = 0;
    t = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (nd_of(sel) === 1'b1) begin found = 1; t = cyc; end
    end
    chk("new_data_seen", 32'(found), 32'd1);
  endtask

  // Start a single frame; returns the cycle stamp of the accepting edge.
  task automatic launch(input int sel, input logic [7:0] d, output int a);
    @(negedge clk);
    drv(sel, 1'b1, d);
    @(negedge clk);
    a = cyc;
    drv(sel, 1'b0, d);
    rise2 = 0; rise0 = 0; ones2 = 0;
  endtask

  int a, t1, t2, nd0;

  initial begin
    n_checks = 0; n_fail = 0;
    loop2 = 1; loop0 = 1; mc2 = 0; mc0 = 0;
    rst_n2 = 0; rst_n0 = 0;
    drv(2, 1'b1, 8'h55);
    drv(0, 1'b1, 8'h55);
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(if2.busy), 32'd0);
    chk("rst_ss_n", 32'(if2.ss_n), 32'd1);
    rst_n2 = 1; rst_n0 = 1;
    drv(2, 1'b0, 8'h00);
    drv(0, 1'b0, 8'h00);
    @(negedge clk);
    chk("rst_data_out", 32'(if2.data_out), 32'h00);
    chk("rst_new_data", 32'(if2.new_data), 32'd0);
    chk("rst_sck",      32'(if0.sck),      32'd0);

    // loopback 0xA5
    launch(2, 8'hA5, a);
    wait_nd(2, 200, t1);
    chk("a5_latency",  32'(t1 - a),      32'd64);
    chk("a5_data_out", 32'(if2.data_out), 32'hA5);
    repeat (2) @(negedge clk);
    chk("a5_rises", 32'(rise2), 32'd8);

    // miso stuck high, zero byte out
    loop2 = 0; mc2 = 1;
    launch(2, 8'h00, a);
    wait_nd(2, 200, t1);
    chk("ff_data_out", 32'(if2.data_out), 32'hFF);
    repeat (2) @(negedge clk);
    chk("ff_rises",      32'(rise2), 32'd8);
    chk("ff_mosi_ones",  32'(ones2), 32'd0);
    loop2 = 1; mc2 = 0;

    // starts mid-frame must be ignored
    nd0 = nd_tot2;
    launch(2, 8'h3C, a);
    for (int k = 1; k <= 40; k++) begin
      if (k == 5 || k == 30) drv(2, 1'b1, 8'hFF);
      else drv(2, 1'b0, 8'h3C);
      @(negedge clk);
    end
    drv(2, 1'b0, 8'h3C);
    wait_nd(2, 200, t1);
    chk("3c_latency",  32'(t1 - a),       32'd64);
    chk("3c_data_out", 32'(if2.data_out), 32'h3C);
    repeat (80) @(negedge clk);
    chk("3c_single_nd", 32'(nd_tot2 - nd0), 32'd1);

    // back-to-back with start held high
    @(negedge clk);
    drv(2, 1'b1, 8'h81);
    @(negedge clk);
    a = cyc;
    drv(2, 1'b1, 8'h7E);
    wait_nd(2, 200, t1);
    chk("b2b_lat1",  32'(t1 - a),        32'd64);
    chk("b2b_dout1", 32'(if2.data_out),  32'h81);
    chk("b2b_gap_ss_n", 32'(if2.ss_n),   32'd1);
    @(negedge clk);
    drv(2, 1'b0, 8'h00);
    chk("b2b_restart_ss_n", 32'(if2.ss_n), 32'd0);
    wait_nd(2, 200, t2);
    chk("b2b_spacing", 32'(t2 - t1),       32'd65);
    chk("b2b_dout2",   32'(if2.data_out),  32'h7E);

    // reset mid-frame aborts
    repeat (3) @(negedge clk);
    nd0 = nd_tot2;
    launch(2, 8'hC3, a);
    repeat (19) @(negedge clk);
    rst_n2 = 0;
    @(negedge clk);
    rst_n2 = 1;
    chk("abort_sck",      32'(if2.sck),      32'd0);
    chk("abort_ss_n",     32'(if2.ss_n),     32'd1);
    chk("abort_busy",     32'(if2.busy),     32'd0);
    chk("abort_data_out", 32'(if2.data_out), 32'h00);
    repeat (100) @(negedge clk);
    chk("abort_no_nd",     32'(nd_tot2 - nd0),  32'd0);
    chk("abort_dout_held", 32'(if2.data_out),   32'h00);

    // fastest divider
    launch(0, 8'h5A, a);
    wait_nd(0, 100, t1);
    chk("d0_latency",  32'(t1 - a),       32'd16);
    chk("d0_data_out", 32'(dout_of(0)),   32'h5A);
    repeat (2) @(negedge clk);
    chk("d0_rises", 32'(rise0), 32'd8);
    chk("d0_nd_count", 32'(nd_tot0), 32'd1);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
